// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, NOP encoding,
// instruction word size and an address-alignment helper.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_slot_buffer.sv
// One {pc, instruction} holding register with clear/load/consume controls.
// Priority is clear > load > consume, so a slot consumed and refilled at the
// same edge ends up full.
module if_slot_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Slot register: empty slots always read back as a zero NOP word and zero pc.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (consume) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the pc, runs the imem req/ack handshake
// and fills the IF/ID output slot, inserting NOP bubbles while waiting.
// Optional build macro IF_PREFETCH_EN adds a one-entry prefetch buffer
// behind the output slot so fetching continues during freeze.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        if_valid,
  output logic        fetch_busy
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  drop_addr;
  logic [31:0]  pc_seq;
  logic         consume;
  logic         room;
  logic         accept;
  logic         stay_req;
  logic         slot_load;
  logic [31:0]  slot_load_pc;
  logic [31:0]  slot_load_instr;

  assign pc_seq  = pc + WORD_BYTES;
  assign consume = if_valid & ~freeze;

  // A request in REQ is only raised when its data has somewhere to land, so
  // once raised it stays up until ack: nothing else can fill the space.
  assign imem_req   = (state == DROP) | ((state == REQ) & room);
  assign imem_addr  = (state == DROP) ? drop_addr : pc;
  assign fetch_busy = (state != IDLE);
  assign accept     = (state == REQ) & room & imem_ack & ~branch_taken;

`ifdef IF_PREFETCH_EN
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        buf_load;
  logic        buf_move;

  assign room     = ~if_valid | ~buf_valid | consume;
  assign buf_move = consume & buf_valid;
  // Fresh data goes to the buffer when the slot stays occupied after this edge.
  assign buf_load = accept & if_valid & ~(consume & ~buf_valid);
  assign slot_load       = (accept & ~buf_load) | (buf_move & ~branch_taken);
  assign slot_load_pc    = buf_move ? buf_pc    : pc_seq;
  assign slot_load_instr = buf_move ? buf_instr : imem_rdata;
  // Room remains next cycle unless both entries end up full.
  assign stay_req = ~freeze | ~buf_load;

  if_slot_buffer u_prefetch (
    .clk        (clk),
    .rst        (rst),
    .clear      (branch_taken),
    .load       (buf_load),
    .consume    (buf_move),
    .load_pc    (pc_seq),
    .load_instr (imem_rdata),
    .valid      (buf_valid),
    .pc         (buf_pc),
    .instr      (buf_instr)
  );
`else
  assign room            = ~if_valid | consume;
  assign slot_load       = accept;
  assign slot_load_pc    = pc_seq;
  assign slot_load_instr = imem_rdata;
  // The freshly loaded slot is expected to drain next cycle unless frozen now.
  assign stay_req = ~freeze;
`endif

  if_slot_buffer u_slot (
    .clk        (clk),
    .rst        (rst),
    .clear      (branch_taken),
    .load       (slot_load),
    .consume    (consume),
    .load_pc    (slot_load_pc),
    .load_instr (slot_load_instr),
    .valid      (if_valid),
    .pc         (pc_out),
    .instr      (instruction_out)
  );

  // Fetch FSM and pc: redirects win over acks and freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else if (branch_taken) begin
      pc <= word_align(branch_addr);
      unique case (state)
        REQ: begin
          if (imem_req && !imem_ack) begin
            state     <= DROP;
            drop_addr <= pc;
          end else begin
            state <= REQ;
          end
        end
        // The stale request keeps its address; an ack arriving alongside the
        // newer redirect retires it so the FSM cannot wait forever.
        DROP:    if (imem_ack) state <= REQ;
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        IDLE: if (room) state <= REQ;
        REQ: begin
          if (accept) begin
            pc    <= pc_seq;
            state <= stay_req ? REQ : IDLE;
          end
        end
        DROP:    if (imem_ack) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by
// randomized freeze/redirect/latency traffic against a stream-level model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        if_valid;
  logic        fetch_busy;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .if_valid        (if_valid),
    .fetch_busy      (fetch_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder state.
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;
  int          lat_fixed;
  bit          lat_rand;
  int          lat_max;
  logic [31:0] key;

  // Stream model: the address the next delivered instruction must come from.
  logic [31:0] exp_addr;
  bit          p_valid, p_freeze, p_br;
  logic [31:0] p_instr, p_pc, p_ba;
  int          stall;
  bit          cur_req;
  logic [31:0] cur_addr;

  // Judge the slot after an edge from what the slot and inputs were before it.
  task automatic score();
    if (p_br) begin
      exp_addr = p_ba & ~32'h3;
      check("br_bubble", 32'(if_valid), 32'd0);
      stall = 0;
    end else if (p_valid && p_freeze) begin
      check("hold_instr", instruction_out, p_instr);
      check("hold_pc", pc_out, p_pc);
      check("hold_valid", 32'(if_valid), 32'd1);
      stall = 0;
    end else if (if_valid) begin
      check("deliver_instr", instruction_out, exp_addr ^ key);
      check("deliver_pc", pc_out, exp_addr + 32'd4);
      exp_addr = exp_addr + 32'd4;
      stall = 0;
    end else begin
      check("nop_instr", instruction_out, 32'h0);
      check("nop_pc", pc_out, 32'h0);
      stall++;
      check("progress", 32'(stall <= 16), 32'd1);
      if (stall > 16) stall = 0;
    end
  endtask

  // One clock cycle: called just after a negedge, ends just after the next.
  task automatic step(input bit frz, input bit br, input logic [31:0] ba);
    freeze       = frz;
    branch_taken = br;
    branch_addr  = ba;
    #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    cur_req    = imem_req;
    cur_addr   = imem_addr;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = lat_rand ? int'($urandom_range(lat_max, 0)) : lat_fixed;
        check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      end else begin
        check("addr_stable", imem_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_addr ^ key;
        mem_busy   = 1'b0;
      end else begin
        mem_wait--;
      end
    end else if (mem_busy) begin
      check("req_held", 32'(imem_req), 32'd1);
    end
    p_valid  = if_valid;
    p_instr  = instruction_out;
    p_pc     = pc_out;
    p_freeze = frz;
    p_br     = br;
    p_ba     = ba;
    @(negedge clk);
    score();
  endtask

  task automatic model_reset();
    mem_busy = 1'b0;
    mem_wait = 0;
    mem_addr = 32'h0;
    exp_addr = RESET_PC;
    p_valid  = 1'b0;
    p_freeze = 1'b0;
    p_br     = 1'b0;
    p_instr  = 32'h0;
    p_pc     = 32'h0;
    p_ba     = 32'h0;
    stall    = 0;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    key = 32'h0; lat_fixed = 0; lat_rand = 1'b0; lat_max = 3;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", instruction_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_busy", 32'(fetch_busy), 32'd1);
    rst = 1'b0;

    // Zero-wait memory, rdata = address: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      check("zw_req", 32'(cur_req), 32'd1);
      check("zw_addr", cur_addr, 32'(4 * i));
      check("zw_valid", 32'(if_valid), 32'd1);
      check("zw_instr", instruction_out, 32'(4 * i));
      check("zw_pc", pc_out, 32'(4 * i + 4));
    end

    // Two wait cycles: address held three cycles, two bubbles.
    lat_fixed = 2;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      check("w2_req", 32'(cur_req), 32'd1);
      check("w2_addr", cur_addr, 32'h10);
      check("w2_valid", 32'(if_valid), 32'(i == 2));
    end
    check("w2_instr", instruction_out, 32'h10);

    // Freeze with full slot: held, no request; release issues immediately.
    lat_fixed = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check("frz_req", 32'(cur_req), 32'd0);
      check("frz_instr", instruction_out, 32'h10);
    end
    step(1'b0, 1'b0, 32'h0);
    check("rel_req", 32'(cur_req), 32'd1);
    check("rel_addr", cur_addr, 32'h14);
    check("rel_instr", instruction_out, 32'h14);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("pre_br_instr", instruction_out, 32'h1C);

    // Redirect while the request to 0x20 is outstanding.
    lat_fixed = 3;
    step(1'b0, 1'b0, 32'h0);
    check("br_issue_addr", cur_addr, 32'h20);
    step(1'b0, 1'b1, 32'h100);
    check("br_hold_addr", cur_addr, 32'h20);
    step(1'b0, 1'b0, 32'h0);
    check("drop_addr", cur_addr, 32'h20);
    check("drop_busy", 32'(fetch_busy), 32'd1);
    lat_fixed = 0;
    step(1'b0, 1'b0, 32'h0);
    check("drop_ack_addr", cur_addr, 32'h20);
    check("drop_discard", 32'(if_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check("tgt_addr", cur_addr, 32'h100);
    check("tgt_instr", instruction_out, 32'h100);
    check("tgt_pc", pc_out, 32'h104);

    // Redirect and ack in the same cycle; unaligned target.
    step(1'b0, 1'b1, 32'h103);
    check("ba_addr", cur_addr, 32'h104);
    check("ba_bubble", 32'(if_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check("ba_tgt_addr", cur_addr, 32'h100);
    check("ba_tgt_instr", instruction_out, 32'h100);

    // pc wrap-around.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_last_addr", cur_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_addr", cur_addr, 32'h0);
    check("wrap_pc", pc_out, 32'h4);

    // Reset in the middle of a request to 0x40.
    step(1'b0, 1'b1, 32'h40);
    lat_fixed = 5;
    step(1'b0, 1'b0, 32'h0);
    check("mid_addr", cur_addr, 32'h40);
    #2;
    rst = 1'b1;
    imem_ack = 1'b0;
    #1;
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_instr", instruction_out, 32'h0);
    check("mid_rst_pc", pc_out, 32'h0);
    check("mid_rst_addr", imem_addr, RESET_PC);
    check("mid_rst_req", 32'(imem_req), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    lat_fixed = 0;
    step(1'b0, 1'b0, 32'h0);
    check("post_rst_addr", cur_addr, RESET_PC);
    check("post_rst_valid", 32'(if_valid), 32'd1);

    // Randomized traffic.
    key = $urandom | 32'h1;
    lat_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
